deserializer_1_to_10: RTL



---
 rtl/tmds_pkg.sv | 24 ++
 rtl/tmds_align_fsm.sv | 102 ++++++++++
 rtl/deserializer_1_to_10.sv | 88 ++++++++
 3 files changed

// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: character width, control tokens,
// alignment state encoding and a token-match helper.
package tmds_pkg;

    localparam int TMDS_WORD_W = 10;

    localparam logic [TMDS_WORD_W-1:0] TMDS_CTRL_00 = 10'h354;
    localparam logic [TMDS_WORD_W-1:0] TMDS_CTRL_01 = 10'h0AB;
    localparam logic [TMDS_WORD_W-1:0] TMDS_CTRL_10 = 10'h154;
    localparam logic [TMDS_WORD_W-1:0] TMDS_CTRL_11 = 10'h2AB;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } align_state_e;

    function automatic logic is_ctrl_token(
        input logic [TMDS_WORD_W-1:0] w
    );
        return (w == TMDS_CTRL_00) || (w == TMDS_CTRL_01) ||
               (w == TMDS_CTRL_10) || (w == TMDS_CTRL_11);
    endfunction

endpackage

// File: rtl/tmds_align_fsm.sv
// Word-boundary alignment FSM: counts token hits/misses per captured word,
// bit-slips while searching, declares and drops lock.
// Ports: clk_i, rst_ni (async, active-low), cap_i (capture strobe),
//        tok_i (captured word is a control token), aligned_o, slip_pos_o[3:0].
module tmds_align_fsm
    import tmds_pkg::*;
#(
    parameter int SEARCH_WORDS = 4096,
    parameter int LOCK_TOKENS  = 8,
    parameter int LOSS_WORDS   = 8192
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       cap_i,
    input  logic       tok_i,
    output logic       aligned_o,
    output logic [3:0] slip_pos_o
);

    localparam logic [8:0]  LOCK_N = 9'(LOCK_TOKENS);
    localparam logic [16:0] SRCH_N = 17'(SEARCH_WORDS);
    localparam logic [16:0] LOSS_N = 17'(LOSS_WORDS);

    align_state_e state_q, state_d;
    logic [15:0]  miss_q, miss_d;
    logic [7:0]   hit_q, hit_d;
    logic [1:0]   settle_q, settle_d;
    logic [3:0]   slip_q, slip_d;
    logic [16:0]  miss_inc;
    logic [8:0]   hit_inc;

    always_comb begin
        state_d  = state_q;
        miss_d   = miss_q;
        hit_d    = hit_q;
        settle_d = settle_q;
        slip_d   = slip_q;
        miss_inc = {1'b0, miss_q} + 17'd1;
        hit_inc  = {1'b0, hit_q} + 9'd1;
        if (cap_i) begin
            // words straddling the old and new boundary are ignored
            if (settle_q != 2'd0) begin
                settle_d = settle_q - 2'd1;
            end else begin
                unique case (state_q)
                    SEARCH: begin
                        if (tok_i) begin
                            miss_d = '0;
                            if (hit_inc == LOCK_N) begin
                                state_d = LOCKED;
                                hit_d   = '0;
                            end else begin
                                hit_d = hit_inc[7:0];
                            end
                        end else begin
                            hit_d = '0;
                            if (miss_inc == SRCH_N) begin
                                slip_d   = (slip_q == 4'd9) ? 4'd0
                                                            : slip_q + 4'd1;
                                miss_d   = '0;
                                settle_d = 2'd2;
                            end else begin
                                miss_d = miss_inc[15:0];
                            end
                        end
                    end
                    LOCKED: begin
                        if (tok_i) begin
                            miss_d = '0;
                        end else if (miss_inc == LOSS_N) begin
                            state_d = SEARCH;
                            miss_d  = '0;
                            hit_d   = '0;
                        end else begin
                            miss_d = miss_inc[15:0];
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= SEARCH;
            miss_q   <= '0;
            hit_q    <= '0;
            settle_q <= '0;
            slip_q   <= '0;
        end else begin
            state_q  <= state_d;
            miss_q   <= miss_d;
            hit_q    <= hit_d;
            settle_q <= settle_d;
            slip_q   <= slip_d;
        end
    end

    assign aligned_o  = (state_q == LOCKED);
    assign slip_pos_o = slip_q;

endmodule

// File: rtl/deserializer_1_to_10.sv
// TMDS 1:10 deserializer: DDR bit pairs -> aligned 10-bit characters.
// Ports: serial_clk_5x, rst_n (async, active-low), datain_h/datain_l (even/odd
//        bit), data_out[9:0], data_valid, aligned, token_det, slip_pos[3:0].
// Build option DESER_POLARITY_INV_EN inverts both input bits (swapped P/N).
module deserializer_1_to_10
    import tmds_pkg::*;
#(
    parameter int SEARCH_WORDS = 4096,
    parameter int LOCK_TOKENS  = 8,
    parameter int LOSS_WORDS   = 8192
) (
    input  logic                   serial_clk_5x,
    input  logic                   rst_n,
    input  logic                   datain_h,
    input  logic                   datain_l,
    output logic [TMDS_WORD_W-1:0] data_out,
    output logic                   data_valid,
    output logic                   aligned,
    output logic                   token_det,
    output logic [3:0]             slip_pos
);

    logic                   bit_h, bit_l;
    // hist[0] would only ever be shifted out, so it is not stored
    logic [11:1]            hist_q, hist_d;
    logic [2:0]             phase_q, phase_d;
    logic [TMDS_WORD_W-1:0] data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   tok_q, tok_d;
    logic [TMDS_WORD_W-1:0] window;
    logic                   capture;
    logic                   win_tok;

`ifdef DESER_POLARITY_INV_EN
    assign bit_h = ~datain_h;
    assign bit_l = ~datain_l;
`else
    assign bit_h = datain_h;
    assign bit_l = datain_l;
`endif

    // odd offsets take the window one bit older
    assign window  = slip_pos[0] ? hist_q[10:1] : hist_q[11:2];
    assign capture = (phase_q == slip_pos[3:1]);
    assign win_tok = is_ctrl_token(window);

    always_comb begin
        hist_d  = {bit_l, bit_h, hist_q[11:3]};
        phase_d = (phase_q == 3'd4) ? 3'd0 : phase_q + 3'd1;
        data_d  = capture ? window : data_q;
        valid_d = capture;
        tok_d   = capture & win_tok;
    end

    always_ff @(posedge serial_clk_5x or negedge rst_n) begin
        if (!rst_n) begin
            hist_q  <= '0;
            phase_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            tok_q   <= 1'b0;
        end else begin
            hist_q  <= hist_d;
            phase_q <= phase_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            tok_q   <= tok_d;
        end
    end

    tmds_align_fsm #(
        .SEARCH_WORDS (SEARCH_WORDS),
        .LOCK_TOKENS  (LOCK_TOKENS),
        .LOSS_WORDS   (LOSS_WORDS)
    ) u_fsm (
        .clk_i      (serial_clk_5x),
        .rst_ni     (rst_n),
        .cap_i      (capture),
        .tok_i      (win_tok),
        .aligned_o  (aligned),
        .slip_pos_o (slip_pos)
    );

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign token_det  = tok_q;

endmodule
